// File: rtl/serial_full_subtractor.sv
// ---------------------------------------------------------------------------
// serial_full_subtractor
//
// Bit-serial WIDTH-bit subtractor computing D = A - B - Bin, one bit per
// clock, least significant bit first. A single full-subtractor cell is
// time-shared across all bit positions. The borrow between bit positions
// is kept in a register.
//
// A start/busy/done handshake lets a controller issue operations
// back-to-back. A start seen in the DONE cycle launches the next operation
// without an idle cycle in between.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request a new operation (ignored while busy)
//   A     - minuend, captured on the accepted start edge
//   B     - subtrahend, captured on the accepted start edge
//   Bin   - borrow-in, captured on the accepted start edge
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when D/Bout take a new value
//   D     - difference, held until the next completion or reset
//   Bout  - borrow-out, 1 when A < B + Bin (unsigned)
// ---------------------------------------------------------------------------
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    // One extra bit keeps the counter from wrapping, even when WIDTH is a
    // power of two.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT            r_state;
    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_D;
    logic             r_Bout;
    logic             r_busy;
    logic             r_done;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_brNext;
    logic [WIDTH-1:0] w_resNext;
    logic             w_lastBit;

    // Full-subtractor cell working on the current LSBs and the running
    // borrow.
    assign w_a      = r_aSr[0];
    assign w_b      = r_bSr[0];
    assign w_d      = w_a ^ w_b ^ r_br;
    assign w_brNext = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

    // The new difference bit enters at the MSB, so after WIDTH shifts the
    // first bit produced has reached bit 0. The expression uses shifts rather
    // than a part-select so that it stays legal when WIDTH is 1.
    assign w_resNext = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_D;
    assign Bout = r_Bout;

    // Control FSM and datapath in one registered block. Operands are loaded
    // from IDLE or DONE. Each SHIFT edge consumes one bit. The visible
    // result registers change only on the final SHIFT edge, so partial
    // results never appear on D/Bout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_D     <= '0;
            r_Bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_aSr   <= A;
                        r_bSr   <= B;
                        r_br    <= Bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                SHIFT: begin
                    r_aSr <= r_aSr >> 1;
                    r_bSr <= r_bSr >> 1;
                    r_br  <= w_brNext;
                    r_res <= w_resNext;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_lastBit) begin
                        r_D     <= w_resNext;
                        r_Bout  <= w_brNext;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_full_subtractor
//
// Self-checking bench for serial_full_subtractor. It drives two instances:
//   - an 8-bit instance, checked on every cycle against a transaction-level
//     model that tracks the in-flight operation and its arithmetic result;
//   - a 1-bit instance, exercised with the full-subtractor truth table.
//
// Directed scenarios pin literal results and latencies. A long randomized
// run with random starts and occasional resets follows them.
// ---------------------------------------------------------------------------
module tb_serial_full_subtractor;

    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          bin8 = 1'b0;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] d8;
    logic          bout8;

    logic          start1 = 1'b0;
    logic [0:0]    a1 = '0;
    logic [0:0]    b1 = '0;
    logic          bin1 = 1'b0;
    logic          busy1;
    logic          done1;
    logic [0:0]    d1;
    logic          bout1;

    int checks   = 0;
    int failures = 0;

    serial_full_subtractor #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .D     (d8),
        .Bout  (bout8)
    );

    serial_full_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (a1),
        .B     (b1),
        .Bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .D     (d1),
        .Bout  (bout1)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Single comparison point: it counts every check and prints one line for
    // each mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the 8-bit instance. It does not model bit-level
    // behaviour. An operation accepted at edge n is in flight until edge
    // n+W8. At that edge its result is the plain integer difference
    // A-B-Bin, reduced modulo 2^W8, with borrow set when the difference is
    // negative. Reset cancels everything and zeroes the result.
    int            edgeN = 0;
    bit            mValid = 1'b0;
    bit            mActive = 1'b0;
    int            mStart = 0;
    int            mDiff = 0;
    logic [W8-1:0] mA = '0;
    logic [W8-1:0] mB = '0;
    logic          mBin = 1'b0;
    logic [W8-1:0] expD = '0;
    logic          expBout = 1'b0;
    logic          expBusy = 1'b0;
    logic          expDone = 1'b0;

    // Advance the model on every rising edge, then compare all outputs 1 ns
    // later, once the DUT registers have settled.
    always @(posedge clk) begin
        edgeN++;
        expDone = 1'b0;
        if (rst) begin
            mValid  = 1'b1;
            mActive = 1'b0;
            expD    = '0;
            expBout = 1'b0;
        end else if (mValid) begin
            if (mActive && edgeN == mStart + W8) begin
                mDiff   = int'(mA) - int'(mB) - int'(mBin);
                expD    = mDiff[W8-1:0];
                expBout = (mDiff < 0);
                expDone = 1'b1;
                mActive = 1'b0;
            end else if (!mActive && start8) begin
                mActive = 1'b1;
                mStart  = edgeN;
                mA      = a8;
                mB      = b8;
                mBin    = bin8;
            end
        end
        expBusy = mActive;
        if (mValid) begin
            #1;
            checkOutput("model_busy", 32'(busy8), 32'(expBusy));
            checkOutput("model_done", 32'(done8), 32'(expDone));
            checkOutput("model_D",    32'(d8),    32'(expD));
            checkOutput("model_Bout", 32'(bout8), 32'(expBout));
        end
    end

    // Pulse start on the 8-bit instance for one cycle. On return the bench
    // sits at the falling edge of cycle 1, which is the first busy cycle.
    task automatic applyStimulus(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic bin);
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        bin8   = bin;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait a bounded number of cycles for done. Cycle numbers are counted
    // from the accepting edge. An expired bound counts as a failed check.
    task automatic waitDone(input int fromCyc, output int doneCyc, output int busyCnt);
        int cyc;
        cyc     = fromCyc;
        doneCyc = -1;
        busyCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done8) begin
                doneCyc = cyc;
                break;
            end
            if (busy8) busyCnt++;
            @(negedge clk);
            cyc++;
        end
        if (doneCyc < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=none expected=done within 40 cycles");
        end
    endtask

    // Run one full operation and check the literal result, the done cycle
    // and the busy length.
    task automatic runOp(input string name, input logic [W8-1:0] a, input logic [W8-1:0] b,
                         input logic bin, input logic [W8-1:0] eD, input logic eB);
        int dc;
        int bc;
        applyStimulus(a, b, bin);
        waitDone(1, dc, bc);
        checkOutput({name, "_doneCycle"}, 32'(dc), 32'(W8 + 1));
        checkOutput({name, "_busyCycles"}, 32'(bc), 32'(W8));
        checkOutput({name, "_D"}, 32'(d8), 32'(eD));
        checkOutput({name, "_Bout"}, 32'(bout8), 32'(eB));
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        int dc;
        int bc;
        int extra;
        int diff;
        logic [W8-1:0] ra;
        logic [W8-1:0] rb;
        logic rbin;
        logic [2:0] combo;

        $display("[TB] start");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy8", 32'(busy8), 32'd0);
        checkOutput("reset_done8", 32'(done8), 32'd0);
        checkOutput("reset_D8",    32'(d8),    32'd0);
        checkOutput("reset_Bout8", 32'(bout8), 32'd0);
        checkOutput("reset_busy1", 32'(busy1), 32'd0);
        checkOutput("reset_D1",    32'(d1),    32'd0);
        rst = 1'b0;

        // Basic subtraction, then the borrow cases.
        runOp("sub5A23",   8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        runOp("borrow1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
        runOp("borrow0001", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        runOp("borrowFFFF", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // A start pulse in cycle 3 must not disturb the running operation
        // and must not cause a second done pulse.
        applyStimulus(8'h5A, 8'h23, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h11;
        b8     = 8'h22;
        @(negedge clk);
        start8 = 1'b0;
        waitDone(4, dc, bc);
        checkOutput("ignore_doneCycle", 32'(dc), 32'(W8 + 1));
        checkOutput("ignore_D", 32'(d8), 32'h37);
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checkOutput("ignore_extraDone", 32'(extra), 32'd0);

        // With start held high across done, the second operation begins in
        // the very next cycle. Its operands are the values present at the
        // DONE edge.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h5A;
        b8     = 8'h23;
        bin8   = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                a8 = 8'h10;
                b8 = 8'h20;
            end
            if (cyc == 9) begin
                checkOutput("held_done1", 32'(done8), 32'd1);
                checkOutput("held_D1",    32'(d8),    32'h37);
            end
            if (cyc == 10) begin
                checkOutput("held_noIdle", 32'(busy8), 32'd1);
                start8 = 1'b0;
            end
            if (cyc == 18) begin
                checkOutput("held_done2", 32'(done8), 32'd1);
                checkOutput("held_D2",    32'(d8),    32'hF0);
                checkOutput("held_Bout2", 32'(bout8), 32'd1);
            end
        end

        // Reset in cycle 4 aborts the operation and clears the outputs.
        // A fresh operation after the reset must still work.
        repeat (2) @(negedge clk);
        applyStimulus(8'h5A, 8'h23, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy8), 32'd0);
        checkOutput("midrst_done", 32'(done8), 32'd0);
        checkOutput("midrst_D",    32'(d8),    32'd0);
        checkOutput("midrst_Bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        runOp("afterRst", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);

        // Operands scrambled every busy cycle: only the captured values
        // matter.
        for (int n = 0; n < 4; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            diff = int'(ra) - int'(rb) - int'(rbin);
            applyStimulus(ra, rb, rbin);
            for (int cyc = 1; cyc < W8 + 1; cyc++) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                bin8 = 1'($urandom);
                @(negedge clk);
            end
            checkOutput("scramble_done", 32'(done8), 32'd1);
            checkOutput("scramble_D",    32'(d8),    32'(diff & 32'hFF));
            checkOutput("scramble_Bout", 32'(bout8), 32'(diff < 0));
        end

        // 1-bit instance: the full truth table, two rows pinned literally.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            diff  = int'(combo[2]) - int'(combo[1]) - int'(combo[0]);
            @(negedge clk);
            start1 = 1'b1;
            a1     = combo[2];
            b1     = combo[1];
            bin1   = combo[0];
            @(negedge clk);
            start1 = 1'b0;
            checkOutput("w1_busy", 32'(busy1), 32'd1);
            @(negedge clk);
            checkOutput("w1_done", 32'(done1), 32'd1);
            checkOutput("w1_D",    32'(d1),    32'(diff & 1));
            checkOutput("w1_Bout", 32'(bout1), 32'(diff < 0));
            if (i == 3) begin
                checkOutput("w1_011_D",    32'(d1),    32'd0);
                checkOutput("w1_011_Bout", 32'(bout1), 32'd1);
            end
            if (i == 4) begin
                checkOutput("w1_100_D",    32'(d1),    32'd1);
                checkOutput("w1_100_Bout", 32'(bout1), 32'd0);
            end
        end

        // Randomized traffic on the 8-bit instance. The per-cycle model
        // process does all of the checking here.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 99) < 2);
            start8 = ($urandom_range(0, 2) == 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bin8   = 1'($urandom);
        end
        @(negedge clk);
        rst    = 1'b0;
        start8 = 1'b0;
        repeat (W8 + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
